// File: rtl/axi_dw_upsizer_rd.sv
// axi_dw_upsizer_rd: AXI4 read-path width upsizer; narrow bursts pass onto the wide bus and
// each wide R beat is reduced to the narrow slice addressed by the burst's current offset.
// Ports:
//   i_clk, i_rst_n                   clock, asynchronous active-low reset
//   i_s_axi_ar* / o_s_axi_arready    narrow-side read address channel
//   o_s_axi_r*  / i_s_axi_rready     narrow-side read data channel
//   o_m_axi_ar* / i_m_axi_arready    wide-side read address channel (fields forwarded)
//   i_m_axi_r*  / o_m_axi_rready     wide-side read data channel
module axi_dw_upsizer_rd #(
    parameter int ADDR_WIDTH      = 32,
    parameter int S_DATA_WIDTH    = 32,
    parameter int M_DATA_WIDTH    = 64,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ARUSER_WIDTH    = 1,
    parameter int RUSER_WIDTH     = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [ID_WIDTH-1:0]     i_s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   i_s_axi_araddr,
    input  logic [7:0]              i_s_axi_arlen,
    input  logic [2:0]              i_s_axi_arsize,
    input  logic [1:0]              i_s_axi_arburst,
    input  logic                    i_s_axi_arlock,
    input  logic [3:0]              i_s_axi_arcache,
    input  logic [2:0]              i_s_axi_arprot,
    input  logic [3:0]              i_s_axi_arqos,
    input  logic [3:0]              i_s_axi_arregion,
    input  logic [ARUSER_WIDTH-1:0] i_s_axi_aruser,
    input  logic                    i_s_axi_arvalid,
    output logic                    o_s_axi_arready,
    output logic [ID_WIDTH-1:0]     o_s_axi_rid,
    output logic [S_DATA_WIDTH-1:0] o_s_axi_rdata,
    output logic [1:0]              o_s_axi_rresp,
    output logic                    o_s_axi_rlast,
    output logic [RUSER_WIDTH-1:0]  o_s_axi_ruser,
    output logic                    o_s_axi_rvalid,
    input  logic                    i_s_axi_rready,
    output logic [ID_WIDTH-1:0]     o_m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   o_m_axi_araddr,
    output logic [7:0]              o_m_axi_arlen,
    output logic [2:0]              o_m_axi_arsize,
    output logic [1:0]              o_m_axi_arburst,
    output logic                    o_m_axi_arlock,
    output logic [3:0]              o_m_axi_arcache,
    output logic [2:0]              o_m_axi_arprot,
    output logic [3:0]              o_m_axi_arqos,
    output logic [3:0]              o_m_axi_arregion,
    output logic [ARUSER_WIDTH-1:0] o_m_axi_aruser,
    output logic                    o_m_axi_arvalid,
    input  logic                    i_m_axi_arready,
    input  logic [ID_WIDTH-1:0]     i_m_axi_rid,
    input  logic [M_DATA_WIDTH-1:0] i_m_axi_rdata,
    input  logic [1:0]              i_m_axi_rresp,
    input  logic                    i_m_axi_rlast,
    input  logic [RUSER_WIDTH-1:0]  i_m_axi_ruser,
    input  logic                    i_m_axi_rvalid,
    output logic                    o_m_axi_rready
);
    localparam int SB = S_DATA_WIDTH / 8;
    localparam int MB = M_DATA_WIDTH / 8;
    localparam int OW = $clog2(MB);
    localparam int SW = $clog2(SB);
    localparam int PW = $clog2(MAX_OUTSTANDING);

    logic [OW-1:0]       r_fifo_off   [MAX_OUTSTANDING];
    logic [2:0]          r_fifo_size  [MAX_OUTSTANDING];
    logic [1:0]          r_fifo_burst [MAX_OUTSTANDING];
    logic [7:0]          r_fifo_len   [MAX_OUTSTANDING];
    logic [PW-1:0]       r_wptr, r_rptr;
    logic [PW:0]         r_count;
    logic [ID_WIDTH-1:0] r_cur_id;
    logic [OW-1:0]       r_off;
    logic                r_first;

    logic          w_full, w_empty, w_ar_ok, w_push, w_r_hs, w_pop;
    logic [OW-1:0] w_off, w_off_next, w_incr, w_wrap, w_wmask, w_lane;
    logic [OW:0]   w_off_x, w_sz;
    logic [2:0]    w_size;
    logic [1:0]    w_burst;
    logic [7:0]    w_len;
    logic [16:0]   w_tot;

    assign w_full  = r_count == (PW+1)'(MAX_OUTSTANDING);
    assign w_empty = r_count == '0;
    // Only same-ID bursts may stack up, so R beats return in FIFO order.
    assign w_ar_ok = !w_full && (w_empty || i_s_axi_arid == r_cur_id);

    assign o_m_axi_arid     = i_s_axi_arid;
    assign o_m_axi_araddr   = i_s_axi_araddr;
    assign o_m_axi_arlen    = i_s_axi_arlen;
    assign o_m_axi_arsize   = i_s_axi_arsize;
    assign o_m_axi_arburst  = i_s_axi_arburst;
    assign o_m_axi_arlock   = i_s_axi_arlock;
    assign o_m_axi_arcache  = i_s_axi_arcache;
    assign o_m_axi_arprot   = i_s_axi_arprot;
    assign o_m_axi_arqos    = i_s_axi_arqos;
    assign o_m_axi_arregion = i_s_axi_arregion;
    assign o_m_axi_aruser   = i_s_axi_aruser;
    assign o_m_axi_arvalid  = i_s_axi_arvalid && w_ar_ok;
    assign o_s_axi_arready  = i_m_axi_arready && w_ar_ok;

    assign o_s_axi_rvalid = i_m_axi_rvalid && !w_empty;
    assign o_m_axi_rready = i_s_axi_rready && !w_empty;
    assign o_s_axi_rid    = i_m_axi_rid;
    assign o_s_axi_rresp  = i_m_axi_rresp;
    assign o_s_axi_rlast  = i_m_axi_rlast;
    assign o_s_axi_ruser  = i_m_axi_ruser;

    assign w_push = i_s_axi_arvalid && o_s_axi_arready;
    assign w_r_hs = i_m_axi_rvalid && o_m_axi_rready;
    assign w_pop  = w_r_hs && i_m_axi_rlast;

    // First beat of a burst takes its offset from the FIFO head; later beats from r_off.
    assign w_off   = r_first ? r_fifo_off[r_rptr] : r_off;
    assign w_size  = r_fifo_size[r_rptr];
    assign w_burst = r_fifo_burst[r_rptr];
    assign w_len   = r_fifo_len[r_rptr];
    assign w_off_x = {1'b0, w_off};
    assign w_sz    = (OW+1)'(1) << w_size;
    // INCR aligns down after the first beat and wraps modulo the wide bus width.
    assign w_incr  = OW'((w_off_x & ~(w_sz - 1'b1)) + w_sz);
    // WRAP window is the burst length in bytes, capped at one wide beat.
    assign w_tot   = (17'(w_len) + 17'd1) << w_size;
    assign w_wmask = (w_tot >= 17'(MB)) ? '1 : OW'(w_tot - 17'd1);
    assign w_wrap  = (w_off & ~w_wmask) | (OW'(w_off_x + w_sz) & w_wmask);

    assign w_off_next = (w_burst == 2'b00) ? w_off : (w_burst == 2'b10) ? w_wrap : w_incr;

    assign w_lane        = w_off >> SW;
    assign o_s_axi_rdata = S_DATA_WIDTH'(i_m_axi_rdata >> (32'(w_lane) * S_DATA_WIDTH));

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_off[r_wptr]   <= i_s_axi_araddr[OW-1:0];
            r_fifo_size[r_wptr]  <= i_s_axi_arsize;
            r_fifo_burst[r_wptr] <= i_s_axi_arburst;
            r_fifo_len[r_wptr]   <= i_s_axi_arlen;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_cur_id <= '0;
            r_off    <= '0;
            r_first  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr   <= r_wptr + PW'(1);
                r_cur_id <= i_s_axi_arid;
            end
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
            if (w_r_hs) begin
                r_off   <= w_off_next;
                r_first <= i_m_axi_rlast;
            end
        end
    end

    a_arsize: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_s_axi_arvalid |-> (i_s_axi_arsize <= 3'(SW)));
    a_r_orphan: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_m_axi_rvalid |-> !w_empty);
endmodule

// File: tb/tb_axi_dw_upsizer_rd.sv
// tb_axi_dw_upsizer_rd: self-checking bench for axi_dw_upsizer_rd (S=32, M=64, depth 4).
module tb_axi_dw_upsizer_rd;
    typedef struct {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [15:0] lanes;
    } vec_t;
    typedef struct {
        logic [7:0] id;
        logic [7:0] len;
    } brst_t;
    typedef struct {
        logic [31:0] data;
        logic [7:0]  id;
        logic [1:0]  resp;
        logic        last;
        logic        user;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]  s_arid, m_arid, s_rid, m_rid;
    logic [31:0] s_araddr, m_araddr, s_rdata;
    logic [63:0] m_rdata;
    logic [7:0]  s_arlen, m_arlen;
    logic [2:0]  s_arsize, m_arsize, s_arprot, m_arprot;
    logic [1:0]  s_arburst, m_arburst, s_rresp, m_rresp;
    logic        s_arlock, m_arlock, s_aruser, m_aruser;
    logic [3:0]  s_arcache, m_arcache, s_arqos, m_arqos, s_arregion, m_arregion;
    logic        s_arvalid, s_arready, m_arvalid, m_arready;
    logic        s_rlast, m_rlast, s_ruser, m_ruser;
    logic        s_rvalid, s_rready, m_rvalid, m_rready;

    axi_dw_upsizer_rd dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s_axi_arid(s_arid), .i_s_axi_araddr(s_araddr), .i_s_axi_arlen(s_arlen),
        .i_s_axi_arsize(s_arsize), .i_s_axi_arburst(s_arburst), .i_s_axi_arlock(s_arlock),
        .i_s_axi_arcache(s_arcache), .i_s_axi_arprot(s_arprot), .i_s_axi_arqos(s_arqos),
        .i_s_axi_arregion(s_arregion), .i_s_axi_aruser(s_aruser),
        .i_s_axi_arvalid(s_arvalid), .o_s_axi_arready(s_arready),
        .o_s_axi_rid(s_rid), .o_s_axi_rdata(s_rdata), .o_s_axi_rresp(s_rresp),
        .o_s_axi_rlast(s_rlast), .o_s_axi_ruser(s_ruser),
        .o_s_axi_rvalid(s_rvalid), .i_s_axi_rready(s_rready),
        .o_m_axi_arid(m_arid), .o_m_axi_araddr(m_araddr), .o_m_axi_arlen(m_arlen),
        .o_m_axi_arsize(m_arsize), .o_m_axi_arburst(m_arburst), .o_m_axi_arlock(m_arlock),
        .o_m_axi_arcache(m_arcache), .o_m_axi_arprot(m_arprot), .o_m_axi_arqos(m_arqos),
        .o_m_axi_arregion(m_arregion), .o_m_axi_aruser(m_aruser),
        .o_m_axi_arvalid(m_arvalid), .i_m_axi_arready(m_arready),
        .i_m_axi_rid(m_rid), .i_m_axi_rdata(m_rdata), .i_m_axi_rresp(m_rresp),
        .i_m_axi_rlast(m_rlast), .i_m_axi_ruser(m_ruser),
        .i_m_axi_rvalid(m_rvalid), .o_m_axi_rready(m_rready)
    );

    brst_t sq[$];
    bit    lane_q[$];
    exp_t  sb[$];
    int    total = 0, bad = 0, cyc = 0, nbeats = 0, first_last = -1;
    bit    arm_last = 1'b0, r_en = 1'b0, rr_rand = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Wide-side slave: drives one beat of the expected slice per call and queues the expectation.
    task automatic drive_beat(input brst_t b, input int bt);
        bit   ln;
        exp_t e;
        m_rid    = b.id;
        m_rdata  = {$urandom, $urandom};
        m_rresp  = 2'($urandom_range(0, 3));
        m_ruser  = 1'($urandom_range(0, 1));
        m_rlast  = (bt == int'(b.len));
        m_rvalid = 1'b1;
        if (lane_q.size() == 0) begin
            chk("lane_q_empty", 1, 0);
            ln = 1'b0;
        end else
            ln = lane_q.pop_front();
        e.data = ln ? m_rdata[63:32] : m_rdata[31:0];
        e.id   = b.id;
        e.resp = m_rresp;
        e.last = m_rlast;
        e.user = m_ruser;
        sb.push_back(e);
    endtask

    initial begin
        brst_t cur;
        int    beat;
        bit    hs;
        m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_ruser = 1'b0;
        beat = 0;
        cur  = '{default: '0};
        forever begin
            @(negedge clk);
            hs = m_rvalid && m_rready;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_rvalid = 1'b0;
                sq.delete();
            end else begin
                if (hs) begin
                    if (beat == int'(cur.len)) begin
                        m_rvalid = 1'b0;
                        void'(sq.pop_front());
                    end else begin
                        beat++;
                        drive_beat(cur, beat);
                    end
                end
                if (!m_rvalid && r_en && sq.size() > 0) begin
                    cur  = sq[0];
                    beat = 0;
                    drive_beat(cur, beat);
                end
            end
        end
    end

    initial begin
        s_rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            s_rready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Narrow-side monitor: the beat visible at a negedge with valid&ready transfers on the next posedge.
    initial forever begin
        @(negedge clk);
        if (rst_n && s_rvalid && s_rready) begin
            nbeats++;
            if (s_rlast && arm_last) begin
                first_last = cyc + 1;
                arm_last   = 1'b0;
            end
            if (sb.size() == 0)
                chk("unexpected_beat", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", s_rdata, e.data);
                chk("rside", {s_rid, s_rresp, s_rlast, s_ruser}, {e.id, e.resp, e.last, e.user});
            end
        end
    end

    // Presents one AR; with n_stall>0 it first expects that many refused cycles, then releases R.
    task automatic send_ar(input vec_t v, input int n_stall, output int acc);
        @(posedge clk);
        #1;
        s_arid = v.id; s_araddr = v.addr; s_arlen = v.len; s_arsize = v.size; s_arburst = v.burst;
        s_arlock = v.addr[0]; s_arcache = v.addr[7:4]; s_arprot = v.addr[10:8];
        s_arqos = v.id[3:0]; s_arregion = v.addr[15:12]; s_aruser = v.id[0];
        s_arvalid = 1'b1;
        acc = -1;
        @(negedge clk);
        chk("ar_fwd",
            {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot,
             m_arqos, m_arregion, m_aruser},
            {v.id, v.addr, v.len, v.size, v.burst, v.addr[0], v.addr[7:4], v.addr[10:8],
             v.id[3:0], v.addr[15:12], v.id[0]});
        for (int i = 0; i < n_stall; i++) begin
            chk("stall_arready", s_arready, 0);
            chk("stall_arvalid", m_arvalid, 0);
            @(negedge clk);
        end
        if (n_stall > 0) begin
            arm_last = 1'b1;
            r_en     = 1'b1;
        end
        for (int i = 0; i < 200 && acc < 0; i++) begin
            chk("ar_pair", m_arvalid, s_arready);
            if (s_arready) begin
                acc = cyc + 1;
                sq.push_back('{v.id, v.len});
                for (int b = 0; b <= int'(v.len); b++) lane_q.push_back(v.lanes[b]);
            end else
                @(negedge clk);
        end
        if (acc < 0) chk("ar_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_arvalid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = sq.size() == 0 && sb.size() == 0 && !m_rvalid;
        end
        chk("drain", done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[13];
        vec_t v;
        int   acc, nb;
        vt[0]  = '{8'h10, 32'h1004, 8'd3,  3'd2, 2'b01, 16'h0005};
        vt[1]  = '{8'h11, 32'h1002, 8'd1,  3'd2, 2'b01, 16'h0002};
        vt[2]  = '{8'h12, 32'h2004, 8'd1,  3'd2, 2'b10, 16'h0001};
        vt[3]  = '{8'h13, 32'h3004, 8'd2,  3'd2, 2'b00, 16'h0007};
        vt[4]  = '{8'h14, 32'h4001, 8'd7,  3'd0, 2'b01, 16'h0078};
        vt[5]  = '{8'h15, 32'h500C, 8'd3,  3'd2, 2'b10, 16'h0005};
        vt[6]  = '{8'h16, 32'h6006, 8'd3,  3'd1, 2'b01, 16'h0009};
        vt[7]  = '{8'h17, 32'h7006, 8'd3,  3'd0, 2'b10, 16'h000F};
        vt[8]  = '{8'h18, 32'h8004, 8'd1,  3'd2, 2'b11, 16'h0001};
        vt[9]  = '{8'h19, 32'h9000, 8'd0,  3'd2, 2'b01, 16'h0000};
        vt[10] = '{8'h1A, 32'hA000, 8'd15, 3'd2, 2'b01, 16'hAAAA};
        vt[11] = '{8'h1B, 32'hB018, 8'd7,  3'd2, 2'b10, 16'h00AA};
        vt[12] = '{8'h1C, 32'hC006, 8'd1,  3'd1, 2'b00, 16'h0003};

        rst_n = 1'b0;
        s_arid = 8'h7; s_araddr = 32'h0; s_arlen = 8'd0; s_arsize = 3'd2; s_arburst = 2'b01;
        s_arlock = 1'b0; s_arcache = '0; s_arprot = '0; s_arqos = '0; s_arregion = '0; s_aruser = 1'b0;
        s_arvalid = 1'b1;
        m_arready = 1'b1;
        #2;
        chk("rst_s_rvalid", s_rvalid, 0);
        chk("rst_m_rready", m_rready, 0);
        chk("rst_arready", s_arready, 1);
        chk("rst_arvalid", m_arvalid, 1);
        m_arready = 1'b0;
        #1;
        chk("rst_arready_lo", s_arready, 0);
        s_arvalid = 1'b0;
        #1;
        chk("rst_arvalid_lo", m_arvalid, 0);
        m_arready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_rvalid", s_rvalid, 0);
        chk("post_rst_m_rready", m_rready, 0);
        chk("post_rst_arready", s_arready, 1);

        for (int i = 0; i < 13; i++) begin
            rr_rand = (i % 2) == 1;
            r_en    = 1'b1;
            nb      = nbeats;
            send_ar(vt[i], 0, acc);
            wait_drain();
            chk("beats", nbeats - nb, int'(vt[i].len) + 1);
        end

        rr_rand = 1'b0;
        r_en    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v    = vt[k];
            v.id = 8'd3;
            send_ar(v, 0, acc);
        end
        v    = vt[4];
        v.id = 8'd3;
        send_ar(v, 3, acc);
        chk("full_release", acc, first_last + 1);
        wait_drain();

        r_en = 1'b0;
        v    = vt[1];
        v.id = 8'd1;
        send_ar(v, 0, acc);
        v       = vt[9];
        v.id    = 8'd2;
        v.addr  = 32'h24;
        v.lanes = 16'h0001;
        send_ar(v, 3, acc);
        chk("id_release", acc, first_last + 1);
        wait_drain();

        r_en    = 1'b1;
        rr_rand = 1'b0;
        v       = vt[0];
        v.id    = 8'd5;
        nb      = nbeats;
        send_ar(v, 0, acc);
        for (int i = 0; i < 50 && nbeats < nb + 1; i++) begin
            @(posedge clk);
            #3;
        end
        chk("mid_burst_reached", nbeats - nb, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_s_rvalid", s_rvalid, 0);
        chk("async_rst_m_rready", m_rready, 0);
        @(posedge clk);
        #2;
        sb.delete();
        lane_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_s_rvalid", s_rvalid, 0);
        chk("rel_m_rready", m_rready, 0);
        v    = '{8'h06, 32'h2006, 8'd2, 3'd1, 2'b01, 16'h0001};
        nb   = nbeats;
        send_ar(v, 0, acc);
        wait_drain();
        chk("beats_after_rst", nbeats - nb, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
